// File: rtl/pm_pkg.sv
// Shared types and defaults for the pattern-match sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pm_pkg;

    // Sequencer states: waiting for pattern, waiting for data, sweeping offsets, holding a report
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SWEEP = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int N_DEF  = 30;
    localparam int CW_DEF = 16;
    localparam int IDX_W  = 32;

endpackage

// File: rtl/window_cmp.sv
// Offset mux plus equality compare of one N-bit slice of the {prev, cur} window.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module window_cmp #(
    parameter int N  = 30,
    parameter int OW = $clog2(N)
) (
    input  logic [2*N-1:0] w_i,
    input  logic [OW-1:0]  k_i,
    input  logic [N-1:0]   pattern_i,
    output logic           hit_o
);

    // Low half of the mask keeps only the N bits starting at offset k
    localparam logic [2*N-1:0] LOW_MASK = {{N{1'b0}}, {N{1'b1}}};

    logic [2*N-1:0] shifted;

    // Shift the window down by k and compare the low N bits against the pattern
    always_comb begin
        shifted = (w_i >> k_i) & LOW_MASK;
        hit_o   = (shifted == {{N{1'b0}}, pattern_i});
    end

endmodule

// File: rtl/match_sequencer.sv
// Captures a pattern chunk, then sweeps every data chunk one offset per cycle and reports hits.
// Latency: chunk_sig rising edge to first compare is 2 cycles; a full sweep is N cycles plus stalls.
// Backpressure: a held report stalls the sweep; one chunk is buffered, further chunks are dropped and flagged.
module match_sequencer
    import pm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF,
    parameter int OW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  chunk_in,
    input  logic          chunk_sig,
    input  logic          clear,
    output logic          match_valid,
    input  logic          match_ready,
    output logic [31:0]   match_chunk,
    output logic [OW-1:0] match_off,
    output logic [CW-1:0] match_count,
    output logic          pattern_loaded,
    output logic          busy,
    output logic          overrun
);

    state_e           state_q;
    logic             sig_q;
    logic [N-1:0]     pattern_q;
    logic [N-1:0]     prev_q;
    logic [N-1:0]     cur_q;
    logic [N-1:0]     pend_q;
    logic             pend_vld_q;
    logic             prev_vld_q;
    logic [IDX_W-1:0] idx_q;
    logic [OW-1:0]    k_q;
    logic             match_valid_q;
    logic [31:0]      match_chunk_q;
    logic [OW-1:0]    match_off_q;
    logic [CW-1:0]    match_count_q;
    logic             pattern_loaded_q;
    logic             overrun_q;

    logic             evt;
    logic             k_last;
    logic             in_sweep;
    logic             hit;

    // The first data chunk has no older bits, so only offset 0 is meaningful for it
    always_comb begin
        evt      = chunk_sig & ~sig_q;
        k_last   = prev_vld_q ? (k_q == OW'(N - 1)) : 1'b1;
        in_sweep = (state_q == SWEEP) || (state_q == HOLD);
    end

    window_cmp #(
        .N  (N),
        .OW (OW)
    ) u_cmp (
        .w_i       ({prev_q, cur_q}),
        .k_i       (k_q),
        .pattern_i (pattern_q),
        .hit_o     (hit)
    );

    // Edge register for the chunk strobe; a long strobe yields a single event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= chunk_sig;
        end
    end

    // Sequencer FSM with pending buffer, report registers and saturating hit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            pattern_q        <= '0;
            prev_q           <= '0;
            cur_q            <= '0;
            pend_q           <= '0;
            pend_vld_q       <= 1'b0;
            prev_vld_q       <= 1'b0;
            idx_q            <= '0;
            k_q              <= '0;
            match_valid_q    <= 1'b0;
            match_chunk_q    <= '0;
            match_off_q      <= '0;
            match_count_q    <= '0;
            pattern_loaded_q <= 1'b0;
            overrun_q        <= 1'b0;
        end else if (clear) begin
            state_q          <= IDLE;
            pattern_q        <= '0;
            prev_q           <= '0;
            cur_q            <= '0;
            pend_q           <= '0;
            pend_vld_q       <= 1'b0;
            prev_vld_q       <= 1'b0;
            idx_q            <= '0;
            k_q              <= '0;
            match_valid_q    <= 1'b0;
            match_chunk_q    <= '0;
            match_off_q      <= '0;
            match_count_q    <= '0;
            pattern_loaded_q <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            // Chunks arriving mid-sweep park in the single pending slot or are dropped
            if (evt && in_sweep) begin
                if (!pend_vld_q) begin
                    pend_q     <= chunk_in;
                    pend_vld_q <= 1'b1;
                end else begin
                    overrun_q  <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (evt) begin
                        pattern_q        <= chunk_in;
                        pattern_loaded_q <= 1'b1;
                        state_q          <= ARMED;
                    end
                end
                ARMED: begin
                    // The buffered chunk is older, so it goes first; a new event refills the slot
                    if (pend_vld_q) begin
                        cur_q   <= pend_q;
                        k_q     <= '0;
                        state_q <= SWEEP;
                        if (evt) begin
                            pend_q <= chunk_in;
                        end else begin
                            pend_vld_q <= 1'b0;
                        end
                    end else if (evt) begin
                        cur_q   <= chunk_in;
                        k_q     <= '0;
                        state_q <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (hit) begin
                        match_valid_q <= 1'b1;
                        match_chunk_q <= idx_q;
                        match_off_q   <= k_q;
                        if (match_count_q != {CW{1'b1}}) begin
                            match_count_q <= match_count_q + 1'b1;
                        end
                        state_q <= HOLD;
                    end else if (k_last) begin
                        prev_q     <= cur_q;
                        prev_vld_q <= 1'b1;
                        idx_q      <= idx_q + 32'd1;
                        state_q    <= ARMED;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (match_ready) begin
                        match_valid_q <= 1'b0;
                        if (k_last) begin
                            prev_q     <= cur_q;
                            prev_vld_q <= 1'b1;
                            idx_q      <= idx_q + 32'd1;
                            state_q    <= ARMED;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            state_q <= SWEEP;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign match_valid    = match_valid_q;
    assign match_chunk    = match_chunk_q;
    assign match_off      = match_off_q;
    assign match_count    = match_count_q;
    assign pattern_loaded = pattern_loaded_q;
    assign overrun        = overrun_q;
    assign busy           = in_sweep;

endmodule
